// File: rtl/alu_wb_stage.sv
// alu_wb_stage: captures ALU results and flags, owns the status register (SR),
// and drains results to the register-file write port through a 2-entry FIFO.
module alu_wb_stage #(
    parameter int          SIZE   = 16,
    parameter logic [3:0]  SR_IDX = 4'd2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [SIZE-1:0] ALU_OUT,
    input  logic [3:0]      CVNZ_alu,
    input  logic            BW,
    input  logic [3:0]      FLAG_EN,
    input  logic [3:0]      DST_IDX,
    input  logic            WB_EN,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            flush,
    output logic            wb_valid,
    input  logic            wb_ready,
    output logic [3:0]      wb_idx,
    output logic [SIZE-1:0] wb_data,
    output logic [SIZE-1:0] SR_OUT,
    output logic            Cin
);

    // Flag positions inside SR; CVNZ_alu is ordered [3]=C, [2]=V, [1]=N, [0]=Z.
    localparam int SR_C = 0;
    localparam int SR_Z = 1;
    localparam int SR_N = 2;
    localparam int SR_V = 8;

    typedef struct packed {
        logic [3:0]      idx;
        logic [SIZE-1:0] data;
    } entry_t;

    entry_t [1:0]    mem_q, mem_d;
    logic            rd_ptr_q, rd_ptr_d;
    logic            wr_ptr_q, wr_ptr_d;
    logic [1:0]      count_q, count_d;
    logic [SIZE-1:0] sr_q, sr_d;

    logic            accept;
    logic            push;
    logic            pop;
    logic [SIZE-1:0] fmt_data;

    // Handshake flags depend only on registered count, so wb_ready never reaches in_ready.
    assign in_ready = (count_q != 2'd2);
    assign wb_valid = (count_q != 2'd0);
    assign wb_idx   = mem_q[rd_ptr_q].idx;
    assign wb_data  = mem_q[rd_ptr_q].data;
    assign SR_OUT   = sr_q;
    assign Cin      = sr_q[SR_C];

    // Accept/pop decode and result formatting (byte mode clears the upper bits).
    always_comb begin
        accept   = in_valid & in_ready;
        push     = accept & WB_EN;
        pop      = wb_valid & wb_ready;
        fmt_data = BW ? {{(SIZE-8){1'b0}}, ALU_OUT[7:0]} : ALU_OUT;
    end

    // Status register update: an explicit write to SR wins over flag merging;
    // a flushed accept leaves SR untouched.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        sr_d = sr_q;
        if (accept && !flush) begin
            if (WB_EN && (DST_IDX == SR_IDX)) begin
                sr_d = fmt_data;
            end else begin
                if (FLAG_EN[3]) sr_d[SR_C] = CVNZ_alu[3];
                if (FLAG_EN[2]) sr_d[SR_V] = CVNZ_alu[2];
                if (FLAG_EN[1]) sr_d[SR_N] = CVNZ_alu[1];
                if (FLAG_EN[0]) sr_d[SR_Z] = CVNZ_alu[0];
            end
        end
    end

    // FIFO next state: flush empties the buffer and outranks push and pop.
    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = 1'b0;
            wr_ptr_d = 1'b0;
            count_d  = 2'd0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = '{idx: DST_IDX, data: fmt_data};
                wr_ptr_d        = ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_d = ~rd_ptr_q;
            end
            case ({push, pop})
                2'b10:   count_d = count_q + 2'd1;
                2'b01:   count_d = count_q - 2'd1;
                default: count_d = count_q;
            endcase
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the two entries are reset so wb_idx/wb_data read zero out of reset; that is
            // cheap at this depth, whereas a deep storage array would normally be left unreset.
            mem_q    <= '0;
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            count_q  <= 2'd0;
            sr_q     <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            mem_q    <= mem_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            sr_q     <= sr_d;
        end
    end

endmodule

// File: tb/tb_alu_wb_stage.sv
// Directed bench for alu_wb_stage with hand-computed expected values.
module tb_alu_wb_stage;

    localparam int SIZE = 16;

    logic            clk = 1'b0;
    logic            rst;
    logic [SIZE-1:0] ALU_OUT;
    logic [3:0]      CVNZ_alu;
    logic            BW;
    logic [3:0]      FLAG_EN;
    logic [3:0]      DST_IDX;
    logic            WB_EN;
    logic            in_valid;
    logic            in_ready;
    logic            flush;
    logic            wb_valid;
    logic            wb_ready;
    logic [3:0]      wb_idx;
    logic [SIZE-1:0] wb_data;
    logic [SIZE-1:0] SR_OUT;
    logic            Cin;

    int n_checks = 0;
    int n_errors = 0;

    alu_wb_stage #(.SIZE(SIZE), .SR_IDX(4'd2)) dut (
        .clk      (clk),
        .rst      (rst),
        .ALU_OUT  (ALU_OUT),
        .CVNZ_alu (CVNZ_alu),
        .BW       (BW),
        .FLAG_EN  (FLAG_EN),
        .DST_IDX  (DST_IDX),
        .WB_EN    (WB_EN),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .flush    (flush),
        .wb_valid (wb_valid),
        .wb_ready (wb_ready),
        .wb_idx   (wb_idx),
        .wb_data  (wb_data),
        .SR_OUT   (SR_OUT),
        .Cin      (Cin)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [15:0] data, input logic bw,
                         input logic [3:0] dst, input logic wben,
                         input logic [3:0] fen, input logic [3:0] cvnz);
        in_valid = v;
        ALU_OUT  = data;
        BW       = bw;
        DST_IDX  = dst;
        WB_EN    = wben;
        FLAG_EN  = fen;
        CVNZ_alu = cvnz;
    endtask

    initial begin
        rst      = 1'b1;
        flush    = 1'b0;
        wb_ready = 1'b0;
        drive(1'b0, 16'h0, 1'b0, 4'd0, 1'b0, 4'h0, 4'h0);
        #12;
        check("rst_wb_valid", 32'(wb_valid), 32'd0);
        check("rst_wb_idx",   32'(wb_idx),   32'd0);
        check("rst_wb_data",  32'(wb_data),  32'd0);
        check("rst_sr",       32'(SR_OUT),   32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        step();

        // Word result with C set: SR bit0 only.
        drive(1'b1, 16'h1234, 1'b0, 4'd5, 1'b1, 4'hF, 4'b1000);
        wb_ready = 1'b1;
        step();
        drive(1'b0, 16'h0, 1'b0, 4'd0, 1'b0, 4'h0, 4'h0);
        check("t1_wb_valid", 32'(wb_valid), 32'd1);
        check("t1_wb_idx",   32'(wb_idx),   32'd5);
        check("t1_wb_data",  32'(wb_data),  32'h1234);
        check("t1_sr",       32'(SR_OUT),   32'h0001);
        check("t1_cin",      32'(Cin),      32'd1);
        step();
        check("t1_drained",  32'(wb_valid), 32'd0);

        // Byte mode, N only: upper byte cleared, other flags held.
        wb_ready = 1'b0;
        drive(1'b1, 16'hABCD, 1'b1, 4'd3, 1'b1, 4'h2, 4'b0010);
        step();
        drive(1'b0, 16'h0, 1'b0, 4'd0, 1'b0, 4'h0, 4'h0);
        check("t2_wb_data", 32'(wb_data), 32'h00CD);
        check("t2_wb_idx",  32'(wb_idx),  32'd3);
        check("t2_sr",      32'(SR_OUT),  32'h0005);
        wb_ready = 1'b1;
        step();
        check("t2_drained", 32'(wb_valid), 32'd0);

        // Fill to two, third stalls, then drain in order.
        wb_ready = 1'b0;
        drive(1'b1, 16'h0001, 1'b0, 4'd6, 1'b1, 4'h0, 4'h0);
        step();
        check("t3_ready1", 32'(in_ready), 32'd1);
        drive(1'b1, 16'h0002, 1'b0, 4'd7, 1'b1, 4'h0, 4'h0);
        step();
        drive(1'b1, 16'h0003, 1'b0, 4'd8, 1'b1, 4'h0, 4'h0);
        check("t3_full_not_ready", 32'(in_ready), 32'd0);
        step();
        check("t3_head_held", 32'(wb_data), 32'h0001);
        check("t3_idx_held",  32'(wb_idx),  32'd6);
        wb_ready = 1'b1;
        step();
        check("t3_head2",     32'(wb_data),  32'h0002);
        check("t3_ready_ag",  32'(in_ready), 32'd1);
        step();
        drive(1'b0, 16'h0, 1'b0, 4'd0, 1'b0, 4'h0, 4'h0);
        check("t3_head3",     32'(wb_data),  32'h0003);
        check("t3_idx3",      32'(wb_idx),   32'd8);
        check("t3_valid3",    32'(wb_valid), 32'd1);
        step();
        check("t3_empty",     32'(wb_valid), 32'd0);

        // count=1: push and pop in the same cycle.
        wb_ready = 1'b0;
        drive(1'b1, 16'h0011, 1'b0, 4'd4, 1'b1, 4'h0, 4'h0);
        step();
        drive(1'b1, 16'h0007, 1'b0, 4'd9, 1'b1, 4'h0, 4'h0);
        wb_ready = 1'b1;
        step();
        drive(1'b0, 16'h0, 1'b0, 4'd0, 1'b0, 4'h0, 4'h0);
        check("t4_valid",    32'(wb_valid), 32'd1);
        check("t4_head",     32'(wb_data),  32'h0007);
        check("t4_head_idx", 32'(wb_idx),   32'd9);
        check("t4_ready",    32'(in_ready), 32'd1);
        step();
        check("t4_empty",    32'(wb_valid), 32'd0);

        // Explicit SR write wins over flag merge and is also pushed.
        wb_ready = 1'b0;
        drive(1'b1, 16'h0108, 1'b0, 4'd2, 1'b1, 4'hF, 4'b0000);
        step();
        check("t5_sr",       32'(SR_OUT),   32'h0108);
        check("t5_cin",      32'(Cin),      32'd0);
        check("t5_wb_valid", 32'(wb_valid), 32'd1);
        check("t5_wb_idx",   32'(wb_idx),   32'd2);
        check("t5_wb_data",  32'(wb_data),  32'h0108);

        // Fill, then flush with in_valid high: buffer empties, SR unchanged.
        drive(1'b1, 16'h0055, 1'b0, 4'd10, 1'b1, 4'h0, 4'h0);
        step();
        check("t6_full", 32'(in_ready), 32'd0);
        drive(1'b1, 16'h0000, 1'b0, 4'd0, 1'b0, 4'h8, 4'b1000);
        flush = 1'b1;
        step();
        check("t6_wb_valid", 32'(wb_valid), 32'd0);
        check("t6_in_ready", 32'(in_ready), 32'd1);
        check("t6_sr",       32'(SR_OUT),   32'h0108);
        // Flush while an accept is possible: its SR update and push are discarded.
        drive(1'b1, 16'h0033, 1'b0, 4'd5, 1'b1, 4'h8, 4'b1000);
        step();
        flush = 1'b0;
        drive(1'b0, 16'h0, 1'b0, 4'd0, 1'b0, 4'h0, 4'h0);
        check("t6b_wb_valid", 32'(wb_valid), 32'd0);
        check("t6b_sr",       32'(SR_OUT),   32'h0108);

        // WB_EN=0 updates flags but never occupies the buffer.
        drive(1'b1, 16'h0077, 1'b0, 4'd5, 1'b0, 4'h8, 4'b1000);
        step();
        drive(1'b0, 16'h0, 1'b0, 4'd0, 1'b0, 4'h0, 4'h0);
        check("t7_sr",       32'(SR_OUT),   32'h0109);
        check("t7_cin",      32'(Cin),      32'd1);
        check("t7_wb_valid", 32'(wb_valid), 32'd0);

        // Asynchronous reset mid-operation.
        drive(1'b1, 16'h00AA, 1'b0, 4'd11, 1'b1, 4'h0, 4'h0);
        step();
        drive(1'b0, 16'h0, 1'b0, 4'd0, 1'b0, 4'h0, 4'h0);
        check("t8_pre_valid", 32'(wb_valid), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("t8_wb_valid", 32'(wb_valid), 32'd0);
        check("t8_sr",       32'(SR_OUT),   32'd0);
        check("t8_wb_data",  32'(wb_data),  32'd0);
        check("t8_cin",      32'(Cin),      32'd0);
        @(negedge clk);
        rst = 1'b0;
        step();
        check("t8_ready", 32'(in_ready), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_errors);
        $finish;
    end

endmodule
